// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared constants and helpers for the 3x3 convolution path.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

   // Window edge length shared by conv_window_gen and conv_mat.
   localparam int MATRIX_SIZE = 3;

   // Flattened element index of window position (row, col).
   function automatic int win_idx(input int row, input int col);
      return row * MATRIX_SIZE + col;
   endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : One image line of storage, single address, read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Asynchronous read returns the value stored before this cycle's write.
   assign rdata = r_mem[addr];

   // Write the new value at the clock edge; contents need no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen
// Description : Streaming 3x3 window generator feeding conv_mat. Buffers two
//               image lines and emits one flattened window per interior pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen
   import cnn_pkg::*;
#(
   parameter int IMAGE_WIDTH = 8,
   parameter int MATRIX_SIZE = 3,
   parameter int IMG_COLS    = 640,
   parameter int IMG_ROWS    = 480
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic [IMAGE_WIDTH-1:0]                s_pixel,
   input  logic                                  s_sof,
   output logic                                  win_valid,
   input  logic                                  win_ready,
   output logic [IMAGE_WIDTH*MATRIX_SIZE**2-1:0] win_matrix,
   output logic                                  win_eof
);

   localparam int CW = $clog2(IMG_COLS);
   localparam int RW = $clog2(IMG_ROWS);
   localparam logic [CW-1:0] c_col_last = CW'(IMG_COLS - 1);
   localparam logic [RW-1:0] c_row_last = RW'(IMG_ROWS - 1);
   localparam logic [CW-1:0] c_col_two  = CW'(2);
   localparam logic [RW-1:0] c_row_two  = RW'(2);

   // Only a 3x3 window is implemented.
   generate
      if (MATRIX_SIZE != 3 || IMG_COLS < 3 || IMG_ROWS < 3) begin : g_param_check
         $error("conv_window_gen: unsupported parameter set");
      end
   endgenerate

   logic [CW-1:0]          r_col;
   logic [RW-1:0]          r_row;
   logic [CW-1:0]          w_col_cur;
   logic [RW-1:0]          w_row_cur;
   logic                   w_xfer;
   logic                   w_emit;
   logic [IMAGE_WIDTH-1:0] w_line_a;
   logic [IMAGE_WIDTH-1:0] w_line_b;
   logic [IMAGE_WIDTH-1:0] w_new   [3];
   logic [IMAGE_WIDTH-1:0] r_win   [3][3];
   logic [IMAGE_WIDTH-1:0] w_next  [3][3];
   logic [IMAGE_WIDTH*MATRIX_SIZE**2-1:0] w_next_flat;

   // Single-stage pipeline: accept only when the output register is free.
   assign s_ready = !rst && (!win_valid || win_ready);
   assign w_xfer  = s_valid && s_ready;

   // Start-of-frame forces the current pixel to position (0,0).
   assign w_col_cur = s_sof ? '0 : r_col;
   assign w_row_cur = s_sof ? '0 : r_row;
   assign w_emit    = w_xfer && (w_row_cur >= c_row_two) && (w_col_cur >= c_col_two);

   // Line A holds row r-2, line B row r-1; B's old value shifts into A.
   line_buffer #(
      .DEPTH (IMG_COLS),
      .WIDTH (IMAGE_WIDTH)
   ) u_line_a (
      .clk   (clk),
      .we    (w_xfer),
      .addr  (w_col_cur),
      .wdata (w_line_b),
      .rdata (w_line_a)
   );

   line_buffer #(
      .DEPTH (IMG_COLS),
      .WIDTH (IMAGE_WIDTH)
   ) u_line_b (
      .clk   (clk),
      .we    (w_xfer),
      .addr  (w_col_cur),
      .wdata (s_pixel),
      .rdata (w_line_b)
   );

   assign w_new[0] = w_line_a;
   assign w_new[1] = w_line_b;
   assign w_new[2] = s_pixel;

   // Shifted window (new column enters at the right) and its flat packing.
   always_comb begin
      w_next_flat = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 2; c++) begin
            w_next[r][c] = r_win[r][c+1];
         end
         w_next[r][2] = w_new[r];
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_next_flat[win_idx(r, c)*IMAGE_WIDTH +: IMAGE_WIDTH] = w_next[r][c];
         end
      end
   end

   // Raster position counters, advanced on every accepted pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_xfer) begin
         if (w_col_cur == c_col_last) begin
            r_col <= '0;
            r_row <= (w_row_cur == c_row_last) ? '0 : w_row_cur + 1'b1;
         end else begin
            r_col <= w_col_cur + 1'b1;
            r_row <= w_row_cur;
         end
      end
   end

   // 3x3 shift register tracking the most recent three columns.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else if (w_xfer) begin
         r_win <= w_next;
      end
   end

   // Output register: loaded on emission, held until the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid  <= 1'b0;
         win_eof    <= 1'b0;
         win_matrix <= '0;
      end else if (w_emit) begin
         win_valid  <= 1'b1;
         win_eof    <= (w_row_cur == c_row_last) && (w_col_cur == c_col_last);
         win_matrix <= w_next_flat;
      end else if (win_ready) begin
         win_valid  <= 1'b0;
      end
   end

endmodule
`default_nettype wire
